seq_mag_comparator: RTL and testbench

//  Parametrised multi-cycle magnitude comparator; successor to the 2-bit combinational A>B / A=B / A<B block.

---
 rtl/seq_mag_comparator_pkg.sv | 22 ++
 rtl/seq_mag_comparator_digit_cmp.sv | 27 ++
 rtl/seq_mag_comparator.sv | 122 ++++++++++++
 tb/tb_seq_mag_comparator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and elaboration helpers for the digit-serial magnitude comparator.
package seq_mag_comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to index `value` items; never less than one so a single digit still gets a register.
   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int num_digits(input int width, input int digit);
      return (width + digit - 1) / digit;
   endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational DIGIT-bit magnitude comparator with one-hot gt/eq/lt.
// It widens the original 2-bit A>B / A=B / A<B equations to any digit width.
module digit_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] da,
   input  logic [DIGIT-1:0] db,
   output logic             dgt,
   output logic             deq,
   output logic             dlt
);

   logic higher_eq;

   always_comb begin
      // NOTE: every variable gets a value before the loop, so no path leaves one unassigned and no latch is inferred.
      dgt       = 1'b0;
      higher_eq = 1'b1;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         dgt       = dgt | (higher_eq & da[i] & ~db[i]);
         higher_eq = higher_eq & ~(da[i] ^ db[i]);
      end
      deq = higher_eq;
      dlt = ~dgt & ~higher_eq;
   end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per cycle, unsigned or
// two's-complement, valid/ready on both sides, optional early exit on first differing digit.
module seq_mag_comparator
   import seq_mag_comparator_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DIGIT       = 4,
   parameter int SIGNED_MODE = 0,
   parameter int EARLY_EXIT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             busy
);

   localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
   localparam int EXT_W      = NUM_DIGITS * DIGIT;
   localparam int IDX_W      = clog2_min1(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] SIGN_FLIP =
      (SIGNED_MODE != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

   state_t           state, state_nxt;
   logic [EXT_W-1:0] a_q, b_q;
   logic [IDX_W-1:0] idx_q;
   logic             found_q;
   logic             gt_q, eq_q, lt_q;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic             dig_gt, dig_eq, dig_lt;
   logic             capture;

   assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
   assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

   digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
      .da  (a_dig),
      .db  (b_dig),
      .dgt (dig_gt),
      .deq (dig_eq),
      .dlt (dig_lt)
   );

   assign capture = (state == ST_IDLE) && in_valid;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (idx_q == '0)                        state_nxt = ST_DONE;
            else if ((EARLY_EXIT != 0) && !dig_eq) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: operand registers carry no reset; they are always written at capture before anything reads them.
   always_ff @(posedge clk) begin
      if (capture) begin
         a_q <= EXT_W'(a ^ SIGN_FLIP);
         b_q <= EXT_W'(b ^ SIGN_FLIP);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         found_q <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else if (capture) begin
         idx_q   <= LAST_IDX;
         found_q <= 1'b0;
      end else if (state == ST_RUN) begin
         // Only the most significant differing digit decides; later digits are scanned but ignored.
         if (!found_q && !dig_eq) begin
            gt_q    <= dig_gt;
            eq_q    <= 1'b0;
            lt_q    <= dig_lt;
            found_q <= 1'b1;
         end else if (!found_q && (idx_q == '0)) begin
            gt_q <= 1'b0;
            eq_q <= 1'b1;
            lt_q <= 1'b0;
         end
         if (idx_q != '0) idx_q <= idx_q - 1'b1;
      end
   end

   assign gt = gt_q;
   assign eq = eq_q;
   assign lt = lt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench: four comparator configurations checked against an arithmetic reference model.
module tb_seq_mag_comparator;

   localparam int NCFG = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid_s  [NCFG];
   logic        in_ready_s  [NCFG];
   logic [15:0] a_s         [NCFG];
   logic [15:0] b_s         [NCFG];
   logic        out_valid_s [NCFG];
   logic        out_ready_s [NCFG];
   logic        gt_s        [NCFG];
   logic        eq_s        [NCFG];
   logic        lt_s        [NCFG];
   logic        busy_s      [NCFG];

   logic        pending [NCFG];
   logic [2:0]  exp_res [NCFG];
   logic        mon_en;
   int          n_tests;
   int          n_fail;

   typedef struct {
      int          k;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  res;
      int          lat;
      int          hold;
   } vec_t;

   localparam logic [2:0] R_GT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   // 0: 16b unsigned early-exit, 1: 16b unsigned constant-time, 2: 16b signed early-exit, 3: 10b unsigned early-exit
   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_MODE(0), .EARLY_EXIT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
      .gt(gt_s[0]), .eq(eq_s[0]), .lt(lt_s[0]), .busy(busy_s[0]));

   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_MODE(0), .EARLY_EXIT(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
      .gt(gt_s[1]), .eq(eq_s[1]), .lt(lt_s[1]), .busy(busy_s[1]));

   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_MODE(1), .EARLY_EXIT(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
      .gt(gt_s[2]), .eq(eq_s[2]), .lt(lt_s[2]), .busy(busy_s[2]));

   seq_mag_comparator #(.WIDTH(10), .DIGIT(4), .SIGNED_MODE(0), .EARLY_EXIT(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
      .a(a_s[3][9:0]), .b(b_s[3][9:0]), .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]),
      .gt(gt_s[3]), .eq(eq_s[3]), .lt(lt_s[3]), .busy(busy_s[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cfg_w(input int k);
      return (k == 3) ? 10 : 16;
   endfunction

   // Reference: integer compare of the operand values; latency = capture cycle plus one cycle per digit scanned.
   function automatic void model(input int k, input logic [15:0] a, input logic [15:0] b,
                                 output logic [2:0] res, output int lat);
      int     w, n;
      bit     sgn, early;
      longint ma, mb, sa, sb, ta, tb;
      w     = cfg_w(k);
      n     = (w + 3) / 4;
      sgn   = (k == 2);
      early = (k != 1);
      ma = longint'(a) & ((longint'(1) << w) - 1);
      mb = longint'(b) & ((longint'(1) << w) - 1);
      sa = ma;
      sb = mb;
      if (sgn) begin
         if (ma >= (longint'(1) << (w - 1))) sa = ma - (longint'(1) << w);
         if (mb >= (longint'(1) << (w - 1))) sb = mb - (longint'(1) << w);
      end
      res = (sa > sb) ? R_GT : ((sa == sb) ? R_EQ : R_LT);
      ta  = sgn ? (ma ^ (longint'(1) << (w - 1))) : ma;
      tb  = sgn ? (mb ^ (longint'(1) << (w - 1))) : mb;
      lat = n + 1;
      if (early && (ta != tb)) begin
         for (int i = n - 1; i >= 0; i--) begin
            if (((ta >> (4 * i)) & 15) != ((tb >> (4 * i)) & 15)) begin
               lat = n - i + 1;
               break;
            end
         end
      end
   endfunction

   // Per-cycle compare: results while valid, busy/in_ready while in flight, quiet outputs when idle.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         for (int k = 0; k < NCFG; k++) begin
            if (pending[k]) begin
               check($sformatf("cfg%0d in_ready_busy", k), {31'd0, in_ready_s[k]}, 32'd0);
               if (out_valid_s[k]) begin
                  check($sformatf("cfg%0d result", k), {29'd0, gt_s[k], eq_s[k], lt_s[k]}, {29'd0, exp_res[k]});
                  check($sformatf("cfg%0d busy_done", k), {31'd0, busy_s[k]}, 32'd0);
               end else begin
                  check($sformatf("cfg%0d busy_run", k), {31'd0, busy_s[k]}, 32'd1);
               end
            end else begin
               check($sformatf("cfg%0d idle_out_valid", k), {31'd0, out_valid_s[k]}, 32'd0);
               check($sformatf("cfg%0d idle_in_ready", k), {31'd0, in_ready_s[k]}, 32'd1);
            end
         end
      end
   end

   task automatic run_op(input vec_t v);
      logic [2:0] mres;
      int         mlat;
      int         lat;
      int         k;
      k = v.k;
      model(k, v.a, v.b, mres, mlat);
      check($sformatf("model_res cfg%0d %h/%h", k, v.a, v.b), {29'd0, mres}, {29'd0, v.res});
      check($sformatf("model_lat cfg%0d %h/%h", k, v.a, v.b), mlat, v.lat);

      @(negedge clk);
      check($sformatf("cfg%0d ready_before", k), {31'd0, in_ready_s[k]}, 32'd1);
      a_s[k]        = v.a;
      b_s[k]        = v.b;
      in_valid_s[k] = 1'b1;
      exp_res[k]    = mres;
      @(posedge clk);
      #1 pending[k] = 1'b1;
      @(negedge clk);
      // Garbage operands while busy must be ignored.
      a_s[k] = ~v.a;
      b_s[k] = v.a;
      lat = 1;
      while (!out_valid_s[k] && lat < 64) begin
         @(negedge clk);
         in_valid_s[k] = 1'b0;
         lat++;
      end
      in_valid_s[k] = 1'b0;
      check($sformatf("cfg%0d latency %h/%h", k, v.a, v.b), lat, mlat);
      check($sformatf("cfg%0d out_valid", k), {31'd0, out_valid_s[k]}, 32'd1);

      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check($sformatf("cfg%0d hold_valid", k), {31'd0, out_valid_s[k]}, 32'd1);
      end

      out_ready_s[k] = 1'b1;
      @(posedge clk);
      #1 pending[k] = 1'b0;
      @(negedge clk);
      out_ready_s[k] = 1'b0;
      check($sformatf("cfg%0d valid_cleared", k), {31'd0, out_valid_s[k]}, 32'd0);
      check($sformatf("cfg%0d ready_after", k), {31'd0, in_ready_s[k]}, 32'd1);
      check($sformatf("cfg%0d result_held", k), {29'd0, gt_s[k], eq_s[k], lt_s[k]}, {29'd0, mres});
   endtask

   vec_t vecs [13];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      rst_n   = 1'b0;
      for (int k = 0; k < NCFG; k++) begin
         in_valid_s[k]  = 1'b0;
         out_ready_s[k] = 1'b0;
         a_s[k]         = '0;
         b_s[k]         = '0;
         pending[k]     = 1'b0;
         exp_res[k]     = '0;
      end

      vecs = '{
         '{0, 16'h8000, 16'h7FFF, R_GT, 2, 0},
         '{0, 16'hA5A5, 16'hA5A5, R_EQ, 5, 0},
         '{1, 16'hA5A5, 16'hA5A5, R_EQ, 5, 0},
         '{2, 16'hFFFF, 16'h0001, R_LT, 2, 0},
         '{0, 16'hFFFF, 16'h0001, R_GT, 2, 0},
         '{3, 16'h03FF, 16'h03FE, R_GT, 4, 0},
         '{1, 16'h8000, 16'h7FFF, R_GT, 5, 0},
         '{0, 16'h1234, 16'h1243, R_LT, 4, 0},
         '{3, 16'h0200, 16'h01FF, R_GT, 2, 0},
         '{2, 16'h8000, 16'h7FFF, R_LT, 2, 0},
         '{2, 16'h0005, 16'h0003, R_GT, 5, 0},
         '{1, 16'h0000, 16'hFFFF, R_LT, 5, 0},
         '{0, 16'h0001, 16'h0000, R_GT, 5, 5}
      };

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
         check($sformatf("cfg%0d reset in_ready", k), {31'd0, in_ready_s[k]}, 32'd1);
         check($sformatf("cfg%0d reset out_valid", k), {31'd0, out_valid_s[k]}, 32'd0);
         check($sformatf("cfg%0d reset busy", k), {31'd0, busy_s[k]}, 32'd0);
         check($sformatf("cfg%0d reset gt_eq_lt", k), {29'd0, gt_s[k], eq_s[k], lt_s[k]}, 32'd0);
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 13; i++) run_op(vecs[i]);

      // Abort: reset during RUN must discard the compare and emit nothing.
      @(negedge clk);
      a_s[0]        = 16'h1111;
      b_s[0]        = 16'h1111;
      in_valid_s[0] = 1'b1;
      exp_res[0]    = R_EQ;
      @(posedge clk);
      #1 pending[0] = 1'b1;
      @(negedge clk);
      in_valid_s[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 pending[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort in_ready", {31'd0, in_ready_s[0]}, 32'd1);
      check("abort out_valid", {31'd0, out_valid_s[0]}, 32'd0);
      check("abort busy", {31'd0, busy_s[0]}, 32'd0);
      check("abort gt_eq_lt", {29'd0, gt_s[0], eq_s[0], lt_s[0]}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort no_result", {31'd0, out_valid_s[0]}, 32'd0);
      end

      run_op('{0, 16'h4000, 16'h4001, R_LT, 5, 1});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
